// File: rtl/led_mux_scheduler_if.sv
// Lane bus for led_mux_scheduler: three switch-pair sources in; grant, select and lane data out.
// The freeze input exists only when LED_MUX_SCHED_FREEZE_EN is defined.
interface led_mux_scheduler_if;
  logic [2:0] req;
  logic [1:0] din0;
  logic [1:0] din1;
  logic [1:0] din2;
`ifdef LED_MUX_SCHED_FREEZE_EN
  logic       freeze;
`endif
  logic [2:0] gnt;
  logic [1:0] sel;
  logic [1:0] dout;
  logic       busy;

  modport master (
    output req, din0, din1, din2,
`ifdef LED_MUX_SCHED_FREEZE_EN
    output freeze,
`endif
    input  gnt, sel, dout, busy
  );

  modport slave (
    input  req, din0, din1, din2,
`ifdef LED_MUX_SCHED_FREEZE_EN
    input  freeze,
`endif
    output gnt, sel, dout, busy
  );
endinterface

// File: rtl/led_mux_scheduler.sv
// Round-robin, time-sliced owner of the 2-bit LED lane across three sources.
// Optional dwell freeze: define LED_MUX_SCHED_FREEZE_EN.
module led_mux_scheduler #(
  parameter int DWELL = 8
) (
  input  logic              clk,
  input  logic              rst,
  led_mux_scheduler_if.slave bus
);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [1:0]      owner, owner_n;
  logic [1:0]      last, last_n;
  logic [1:0]      dout, dout_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      hit;
  logic            frz;
  logic [2:0][1:0] din_v;

  assign din_v = {bus.din2, bus.din1, bus.din0};

`ifdef LED_MUX_SCHED_FREEZE_EN
  assign frz = bus.freeze;
`else
  assign frz = 1'b0;
`endif

  // Rotating search after+1, after+2, after; the final slot (after itself)
  // is skipped when excl is set. Returns {found, index}.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] after,
                                      input logic excl);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    c   = after;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!res[2] && r[c] && !(excl && k == 2)) res = {1'b1, c};
    end
    return res;
  endfunction

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    dout_n  = dout;
    hit     = 3'b000;
    case (state)
      IDLE: begin
        hit = pick(bus.req, last, 1'b0);
        if (hit[2]) begin
          state_n = GRANT;
          owner_n = hit[1:0];
          last_n  = hit[1:0];
          cnt_n   = RELOAD;
          dout_n  = din_v[hit[1:0]];
        end
      end
      GRANT: begin
        // Owner dropping its request forces an early handover that skips it.
        if (!bus.req[owner] || (cnt == '0 && !frz)) begin
          hit = pick(bus.req, owner, !bus.req[owner]);
          if (hit[2]) begin
            owner_n = hit[1:0];
            last_n  = hit[1:0];
            cnt_n   = RELOAD;
            dout_n  = din_v[hit[1:0]];
          end else begin
            state_n = IDLE;
            dout_n  = 2'b00;
          end
        end else begin
          dout_n = din_v[owner];
          if (!frz) cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      last  <= 2'd2;
      cnt   <= '0;
      dout  <= 2'b00;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
    end
  end

  // Status decodes straight from state so an async reset clears them at once.
  assign bus.gnt  = (state == GRANT) ? (3'b001 << owner) : 3'b000;
  assign bus.sel  = (state == GRANT) ? owner : 2'd3;
  assign bus.busy = (state == GRANT);
  assign bus.dout = dout;
endmodule

// File: tb/tb_led_mux_scheduler.sv
// Directed bench for led_mux_scheduler (DWELL=4): slot-level model compared every cycle,
// plus literal expectations for reset, rotation, early release, sole requester and freeze.
module tb_led_mux_scheduler;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b111;
  logic [1:0] din0 = 2'b01, din1 = 2'b10, din2 = 2'b11;
  logic       freeze = 1'b0;
  int checks = 0;
  int failures = 0;

  led_mux_scheduler_if bus();
  assign bus.req  = req;
  assign bus.din0 = din0;
  assign bus.din1 = din1;
  assign bus.din2 = din2;
`ifdef LED_MUX_SCHED_FREEZE_EN
  assign bus.freeze = freeze;
`endif

  led_mux_scheduler #(.DWELL(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 idle), slots of dwell left, last granted source.
  int         m_own = -1;
  int         m_rem = 0;
  int         m_last = 2;
  logic [1:0] m_dout = 2'b00;

  function automatic int find(input logic [2:0] r, input int after, input int excl);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (after + k) % 3;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [1:0] src_data(input int i);
    case (i)
      0: return din0;
      1: return din1;
      2: return din2;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int  n, rem;
    bit  newg, frz;
    if (rst) begin
      m_own  <= -1;
      m_rem  <= 0;
      m_last <= 2;
      m_dout <= 2'b00;
    end else begin
`ifdef LED_MUX_SCHED_FREEZE_EN
      frz = freeze;
`else
      frz = 1'b0;
`endif
      newg = 1'b0;
      rem  = m_rem;
      if (m_own < 0) begin
        n = find(req, m_last, -1);
        newg = (n >= 0);
      end else if (!req[m_own]) begin
        n = find(req, m_own, m_own);
        newg = (n >= 0);
      end else begin
        if (!frz) rem = rem - 1;
        if (rem == 0) begin
          n = find(req, m_own, -1);
          newg = 1'b1;
        end else n = m_own;
      end
      if (newg) begin
        rem = DW;
        m_last <= n;
      end
      m_rem  <= rem;
      m_own  <= n;
      m_dout <= (n < 0) ? 2'b00 : src_data(n);
    end
  end

  always @(negedge clk) begin
    chk("model_gnt",  {5'd0, bus.gnt},  (m_own < 0) ? 8'd0 : (8'd1 << m_own));
    chk("model_sel",  {6'd0, bus.sel},  (m_own < 0) ? 8'd3 : 8'(m_own));
    chk("model_dout", {6'd0, bus.dout}, {6'd0, m_dout});
    chk("model_busy", {7'd0, bus.busy}, {7'd0, m_own >= 0});
  end

  task automatic wait_gnt(input logic [2:0] g, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.gnt == g) ok = 1'b1;
    end
    chk(name, {7'd0, ok}, 8'd1);
  endtask

  initial begin
    #3;
    chk("rst_gnt",  {5'd0, bus.gnt},  8'd0);
    chk("rst_sel",  {6'd0, bus.sel},  8'd3);
    chk("rst_dout", {6'd0, bus.dout}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Rotation: 001x4, 010x4, 100x4, 001 ... with lane data one cycle behind.
    for (int i = 0; i < 13; i++) begin
      int s;
      logic [1:0] d;
      @(posedge clk); #1;
      s = (i / 4) % 3;
      d = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b11;
      chk("rot_gnt",  {5'd0, bus.gnt},  8'd1 << s);
      chk("rot_dout", {6'd0, bus.dout}, {6'd0, d});
    end

    // Early release on source 1's third cycle hands straight to source 2.
    wait_gnt(3'b010, "wait_src1");
    repeat (2) @(posedge clk);
    #1 req = 3'b101;
    @(posedge clk); #1;
    chk("early_gnt",  {5'd0, bus.gnt},  8'h04);
    chk("early_dout", {6'd0, bus.dout}, 8'h03);

    // Sole requester keeps the lane across re-grants, then idles.
    req = 3'b010;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("sole_gnt", {5'd0, bus.gnt}, 8'h02);
    end
    req = 3'b000;
    @(posedge clk); #1;
    chk("idle_gnt",  {5'd0, bus.gnt},  8'd0);
    chk("idle_sel",  {6'd0, bus.sel},  8'd3);
    chk("idle_dout", {6'd0, bus.dout}, 8'd0);

    // Asynchronous reset mid-grant of source 2.
    req = 3'b111;
    wait_gnt(3'b100, "wait_src2");
    #2 rst = 1'b1;
    #1;
    chk("mrst_gnt",  {5'd0, bus.gnt},  8'd0);
    chk("mrst_sel",  {6'd0, bus.sel},  8'd3);
    chk("mrst_dout", {6'd0, bus.dout}, 8'd0);
    chk("mrst_busy", {7'd0, bus.busy}, 8'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_first", {5'd0, bus.gnt}, 8'h01);

`ifdef LED_MUX_SCHED_FREEZE_EN
    // Freeze holds source 0 for 10 cycles, then its 3 remaining slots run out.
    freeze = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("frz_hold", {5'd0, bus.gnt}, 8'h01);
    end
    freeze = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("frz_tail", {5'd0, bus.gnt}, 8'h01);
    end
    @(posedge clk); #1;
    chk("frz_next", {5'd0, bus.gnt}, 8'h02);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_mux_scheduler.md
# led_mux_scheduler

Round-robin scheduler that shares the 2-bit LED output lane among three switch-pair sources (SW[1:0], SW[3:2], SW[5:4]) and replaces manual SW[9:8] source selection with automatic, time-sliced arbitration. Each requesting source owns the lane for a programmable dwell time. Rotating priority provides fairness. The block drives the registered lane data plus grant/status outputs for the top-level LED wiring.

## Interface
- DWELL, 8: cycles a granted source holds the lane; legal range 1..255.
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  reset, asynchronous and active-high.
- REQ  input  3  per-source request; bit i requests the lane for source i.
- DIN0  input  2  source 0 data (SW[1:0]).
- DIN1  input  2  source 1 data (SW[3:2]).
- DIN2  input  2  source 2 data (SW[5:4]).
- FREEZE  input  1  dwell freeze; present only with LED_MUX_SCHED_FREEZE_EN.
- GNT  output  3  one-hot grant; all zero when idle.
- SEL  output  2  encoded grant: 0/1/2 = source, 3 = idle.
- DOUT  output  2  registered data of the granted source; 0 when idle.
- BUSY  output  1  high while any grant is active.

## Operation
- States: IDLE and GRANT.
- Reset values: GNT=000, SEL=3, DOUT=00, BUSY=0, dwell counter=0, last-grant pointer=2 (source 0 has first priority after reset).
- IDLE: on any REQ bit high, grant the first requester searching upward from last+1, wrapping 2→0. Load counter with DWELL-1 and go to GRANT.
- GRANT: each cycle DOUT <= DIN[granted], counter decrements.
- End of dwell (counter==0 at the edge): re-arbitrate using the same rotating search starting after the current owner.
  - Another requester pending: it takes the grant on the next cycle, with no idle gap.
  - Only the current owner still requesting: it is re-granted for a fresh DWELL.
  - No requesters: go to IDLE, clear GNT, SEL=3, DOUT=00.
- Early release: if the owner's REQ bit is low at an edge in GRANT, treat as end of dwell (re-arbitrate at that edge). The owner is excluded from that search.
- REQ changes of non-owners never disturb the current grant.
- The last-grant pointer updates on every new grant, including a re-grant.
- Counter width is ceil(log2(DWELL+1)). DWELL=1 means a rotation every cycle while multiple sources request.

## Timing
- REQ sampled at edge N → GNT/SEL/BUSY valid after edge N; DOUT shows DIN sampled at edge N (one-cycle latency from DIN to DOUT).
- An uninterrupted grant lasts exactly DWELL cycles.
- Back-to-back handover: GNT changes one-hot to one-hot in a single edge and is never 000 in between.
- At most one GNT bit is high in any cycle.
- RESET asserted mid-grant immediately forces all reset values, without waiting for a clock. After release, the first arbitration occurs at the first rising edge with RESET low.

## Configuration
- LED_MUX_SCHED_FREEZE_EN defined:
  - The FREEZE port exists.
  - While FREEZE=1 in GRANT, the counter holds and the dwell-expiry handover is suppressed. DOUT keeps tracking the owner's DIN.
  - Early release on the owner's REQ drop still applies.
  - FREEZE in IDLE has no effect.
- Not defined: no FREEZE port; the dwell counter always runs.

## Test plan
- Reset: RESET=1 with REQ=111 → GNT=000, SEL=3, DOUT=00, BUSY=0 asynchronously. After release, first edge → GNT=001.
- Rotation, DWELL=4, REQ=111, DIN0=01, DIN1=10, DIN2=11 → GNT sequence 001×4, 010×4, 100×4, 001…; DOUT follows 01/10/11 with one-cycle lag and no idle cycles.
- Early release, DWELL=8: source 1 granted, REQ drops to 101 on its 3rd cycle → next cycle GNT=100.
- Sole requester, REQ=010, DWELL=4 → GNT stays 010 continuously across re-grants. REQ→000 → IDLE next cycle, SEL=3, DOUT=00.
- Mid-grant reset: assert RESET during a source-2 grant → outputs clear without a clock edge. After release with REQ=111, source 0 is granted first.
- FREEZE (macro defined), DWELL=4: FREEZE=1 during a source-0 grant for 10 cycles → GNT stays 001. After FREEZE=0, the remaining dwell cycles complete, then GNT=010.
